// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS load/store port: one request at a time, a programmable
// wait, then a byte-enabled read/write on an internal word array with misalign/range errors.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, commit;

    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        rsp_valid_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_err;
    logic [IdxW-1:0] c_idx;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = LatCnt;
                    if (LatCnt == 4'd0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // With zero latency the commit happens on the accept edge, so use the live request.
    always_comb begin
        if (state_q == StIdle) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else begin
            c_we    = we_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
        c_err  = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH_WORDS));
        c_idx  = c_addr[IdxW+1:2];
        mem_we = commit && c_we && !c_err;
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_we) ? 32'h0 : mem[c_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= (state_d == StResp);
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Array is not cleared, but a write must never land while reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    exp_t qa[$];
    exp_t qb[$];

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitors: compare each new response against the head of its scoreboard.
    logic a_prev = 1'b0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_rsp_valid && !a_prev) begin
            if (qa.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_rsp: got response, expected none");
            end else begin
                e = qa.pop_front();
                chk("a_rdata", a_rsp_rdata, e.rdata);
                chk("a_err", {31'b0, a_rsp_err}, {31'b0, e.err});
            end
        end
        a_prev <= a_rsp_valid;
    end

    logic b_prev = 1'b0;
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_rsp_valid && !b_prev) begin
            if (qb.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_rsp: got response, expected none");
            end else begin
                e = qb.pop_front();
                chk("b_rdata", b_rsp_rdata, e.rdata);
                chk("b_err", {31'b0, b_rsp_err}, {31'b0, e.err});
            end
        end
        b_prev <= b_rsp_valid;
    end

    task automatic wait_ready(input bit sel_b);
        int n = 0;
        @(negedge clk);
        while (!(sel_b ? b_req_ready : a_req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL %s_ready_timeout: got req_ready=0, expected 1", sel_b ? "b" : "a");
        end
    endtask

    // Issue one request on instance A; returns at the negedge of the first rsp_valid cycle
    // if rsp_ready is low, otherwise just after the response handshake.
    task automatic a_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err);
        int n = 0;
        wait_ready(1'b0);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        qa.push_back({exp_rdata, exp_err});
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_rsp_valid && n < 20);
        chk("a_latency", 32'(n), 32'd3);
        if (a_rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bv[4];
        int   last = 0;
        int   acc;

        reset = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;

        @(posedge clk);
        #2;
        chk("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, a_rsp_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        a_xact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        a_xact(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        a_xact(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        a_xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        a_xact(1'b0, 32'h20, 32'h0, 4'b1111, 32'h11BB33DD, 1'b0);

        a_xact(1'b1, 32'h00, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
        a_xact(1'b1, 32'hFC, 32'hCAFE0063, 4'b1111, 32'h0, 1'b0);
        a_xact(1'b0, 32'h22, 32'h0, 4'b1111, 32'h0, 1'b1);
        a_xact(1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
        a_xact(1'b0, 32'h00, 32'h0, 4'b1111, 32'h0BADF00D, 1'b0);
        a_xact(1'b0, 32'hFC, 32'h0, 4'b1111, 32'hCAFE0063, 1'b0);
        a_xact(1'b1, 32'h04, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);

        // Back-pressure with an ignored request pulse in the middle.
        a_rsp_ready = 1'b0;
        a_xact(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
                a_req_wdata = 32'h12345678; a_req_be = 4'b1111;
            end
            if (i == 2) a_req_valid = 1'b0;
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
            chk("bp_rsp_err", {31'b0, a_rsp_err}, 32'd0);
            chk("bp_req_ready", {31'b0, a_req_ready}, 32'd0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_req_ready", {31'b0, a_req_ready}, 32'd1);
        chk("bp_idle_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        a_xact(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0);

        // Reset in the first WAIT cycle drops the write.
        wait_ready(1'b0);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h04;
        a_req_wdata = 32'h55555555; a_req_be = 4'b1111;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("mid_rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("mid_rst_rsp_err", {31'b0, a_rsp_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        a_xact(1'b0, 32'h04, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0);

        // Zero latency: req_valid held high, accepts land every second cycle.
        bv[0] = '{we: 1'b1, addr: 32'h08, wdata: 32'hA5A5A5A5, be: 4'b1111, exp: 32'h0};
        bv[1] = '{we: 1'b0, addr: 32'h08, wdata: 32'h0, be: 4'b1111, exp: 32'hA5A5A5A5};
        bv[2] = '{we: 1'b1, addr: 32'h08, wdata: 32'h5A5A0000, be: 4'b1100, exp: 32'h0};
        bv[3] = '{we: 1'b0, addr: 32'h08, wdata: 32'h0, be: 4'b0000, exp: 32'h5A5AA5A5};
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1'b1;
            b_req_we    = bv[i].we;
            b_req_addr  = bv[i].addr;
            b_req_wdata = bv[i].wdata;
            b_req_be    = bv[i].be;
            qb.push_back({bv[i].exp, 1'b0});
            wait_ready(1'b1);
            @(posedge clk);
            #1 acc = cyc;
            if (i > 0) chk("b_spacing", 32'(acc - last), 32'd2);
            last = acc;
            @(negedge clk);
            chk("b_rsp_valid_lat", {31'b0, b_rsp_valid}, 32'd1);
            chk("b_req_ready_resp", {31'b0, b_req_ready}, 32'd0);
        end
        b_req_valid = 1'b0;

        repeat (4) @(negedge clk);
        chk("a_sb_empty", 32'(qa.size()), 32'd0);
        chk("b_sb_empty", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
